// File: rtl/parallel_serial_tx_pkg.sv
// Shared constants and types for the serial link transmitter and its
// matching deserializer: comma byte, slot width and the link FSM states.
package parallel_serial_tx_pkg;

    localparam logic [7:0] SYNC_WORD_DEF = 8'hBC;
    localparam int SLOT_W = 8;
    localparam int CNT_W = $clog2(SLOT_W);
    localparam int SLOT_CNT_W = 4;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [SLOT_W-1:0] shift_msb_out(
        input logic [SLOT_W-1:0] v
    );
        return {v[SLOT_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/parallel_serial_tx_if.sv
// Upstream byte handshake into the serial transmitter.
// master = byte producer, slave = parallel_serial_tx.
interface parallel_serial_tx_if;
    import parallel_serial_tx_pkg::*;

    logic [SLOT_W-1:0] DATA_IN;
    logic              VALID_IN;
    logic              READY_OUT;

    modport master (
        output DATA_IN,
        output VALID_IN,
        input  READY_OUT
    );

    modport slave (
        input  DATA_IN,
        input  VALID_IN,
        output READY_OUT
    );

endinterface

// File: rtl/parallel_serial_tx_hold.sv
// One-byte holding register between the upstream handshake and the
// slot loader; used only when SKID_BUF_EN is defined.
module tx_hold_reg
    import parallel_serial_tx_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              push_i,
    input  logic [SLOT_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [SLOT_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [SLOT_W-1:0] data_q, data_d;

    // Pop and push on one edge: the old byte leaves, the new one stays.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (pop_i) begin
            valid_d = 1'b0;
        end
        if (push_i) begin
            valid_d = 1'b1;
            data_d  = push_data_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = !valid_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/parallel_serial_tx.sv
// Byte-to-serial transmitter: MSB-first 8-bit slots, comma fill and
// a forced comma preamble after reset. Optional macro: SKID_BUF_EN.
module parallel_serial_tx
    import parallel_serial_tx_pkg::*;
#(
    parameter logic [7:0]  SYNC_WORD  = SYNC_WORD_DEF,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    parallel_serial_tx_if.slave   up,
    output logic                  DATA_OUT,
    output logic                  SLOT_START_OUT,
    output logic                  SYNC_DONE_OUT
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_W - 1);
    localparam logic [SLOT_CNT_W-1:0] SLOT_LAST =
        SLOT_CNT_W'(SYNC_COUNT - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SLOT_W-1:0]       shreg_q, shreg_d;
    logic [SLOT_CNT_W-1:0]   slot_q, slot_d;

    logic                    wrap;
    logic                    ready;
    logic                    accept;
    logic [SLOT_W-1:0]       next_byte;

    assign wrap   = (cnt_q == CNT_LAST);
    assign accept = ready && up.VALID_IN;

`ifdef SKID_BUF_EN
    logic              hold_ready;
    logic              hold_valid;
    logic [SLOT_W-1:0] hold_data;
    logic              hold_pop;

    assign hold_pop = wrap && hold_valid;

    tx_hold_reg u_hold (
        .CLK         (CLK),
        .RESET       (RESET),
        .push_i      (accept),
        .push_data_i (up.DATA_IN),
        .pop_i       (hold_pop),
        .ready_o     (hold_ready),
        .valid_o     (hold_valid),
        .data_o      (hold_data)
    );

    // A byte accepted on a wrap edge waits for the following wrap.
    always_comb begin
        ready     = (state_q == RUN) && hold_ready;
        next_byte = hold_valid ? hold_data : SYNC_WORD;
    end
`else
    // Direct path: the byte is taken only on the wrap cycle.
    always_comb begin
        ready     = (state_q == RUN) && wrap;
        next_byte = accept ? up.DATA_IN : SYNC_WORD;
    end
`endif

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        shreg_d = shift_msb_out(shreg_q);
        state_d = state_q;
        slot_d  = slot_q;

        if (wrap) begin
            shreg_d = next_byte;
        end

        unique case (state_q)
            SYNC: begin
                if (wrap) begin
                    if (slot_q == SLOT_LAST) begin
                        state_d = RUN;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + SLOT_CNT_W'(1);
                    end
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= SYNC;
            cnt_q   <= '0;
            shreg_q <= SYNC_WORD;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            slot_q  <= slot_d;
        end
    end

    assign up.READY_OUT   = ready;
    assign DATA_OUT       = shreg_q[SLOT_W-1];
    assign SLOT_START_OUT = (cnt_q == '0);
    assign SYNC_DONE_OUT  = (state_q == RUN);

endmodule
